// File: rtl/rr_dc_arbiter.sv
// Round-robin arbiter for one decoder-driven resource shared by 2**width requesters.
// Registers the winner's binary index and drives its decoded one-hot grant until release.
module rr_dc_arbiter #(
    parameter int width = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    Ena,
    input  logic [(1<<width)-1:0]   req,
    input  logic                    done,
    output logic [(1<<width)-1:0]   gnt,
    output logic [width-1:0]        gnt_idx,
    output logic                    gnt_valid
);

    localparam int N = 1 << width;

    // Handshake: requester i holds req[i] high until it sees gnt[i]; ownership lasts
    // until done=1 or req[gnt_idx]=0 at a clock edge, after which gnt drops for at least
    // one cycle. Ena only gates leaving IDLE; an owner is never preempted.
    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nxt;
    logic [width-1:0] ptr, ptr_nxt;
    logic [width-1:0] idx_nxt;
    logic [N-1:0]     gnt_nxt;
    logic             valid_nxt;
    logic [width-1:0] winner;
    logic [width-1:0] cand;
    logic             found;

    // Scan starts at ptr and wraps naturally through the width-bit add.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr + k[width-1:0];
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = gnt_idx;
        gnt_nxt   = gnt;
        valid_nxt = gnt_valid;
        case (state)
            IDLE: begin
                if (Ena && found) begin
                    state_nxt = GRANT;
                    idx_nxt   = winner;
                    gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << winner;
                    valid_nxt = 1'b1;
                end
            end
            GRANT: begin
                if (done || !req[gnt_idx]) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    valid_nxt = 1'b0;
                    ptr_nxt   = gnt_idx + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt_idx   <= idx_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= valid_nxt;
        end
    end

endmodule
